lockable_regfile: RTL and testbench

- Parametrised register file on the team's custom chip-select bus, with a working lock: a two-key unlock sequence on a lock-control register that gates writes to a configurable set of data registers.
- Successor to the fixed two-register generated block. Adds parametrised width and depth, distinct addresses, a registered read path, lock enforcement, error reporting, and optional auto-relock.
- Sits between the bus decoder and peripheral configuration logic.

---
 rtl/lockable_regfile.sv | 148 ++++++++++++++
 tb/tb_lockable_regfile.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lockable_regfile.sv
// Register file on the chip-select bus; a two-key write sequence to LOCK_CTRL unlocks the protected data registers.
// Define LOCKABLE_REGFILE_TIMEOUT_EN to add an idle auto-relock after TIMEOUT_CYCLES.
module lockable_regfile #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    NUM_REGS       = 8,
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE      = 'h10,
    parameter logic [NUM_REGS-1:0]   LOCK_MASK      = '1,
    parameter logic [DATA_WIDTH-1:0] KEY1           = 'hA5A5,
    parameter logic [DATA_WIDTH-1:0] KEY2           = 'h5A5A,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL      = '0,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           chip_select,
    input  logic                           write_en,
    input  logic                           read_en,
    input  logic [DATA_WIDTH-1:0]          write_data,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           data_valid,
    output logic                           write_err,
    output logic [1:0]                     lock_state,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    // state     | meaning
    // LOCKED    | protected registers reject writes
    // KEY1_SEEN | first key accepted, next LOCK_CTRL write must be KEY2
    // UNLOCKED  | all data registers writable
    localparam logic [1:0] LOCKED    = 2'b00;
    localparam logic [1:0] KEY1_SEEN = 2'b01;
    localparam logic [1:0] UNLOCKED  = 2'b10;

    localparam int                    IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0]   NUM_REGS_A  = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LOCK   = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_data_valid;
    logic                  r_write_err;
    logic [1:0]            r_lock_state;
    logic [7:0]            r_err_cnt;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_is_lock;
    logic                  w_is_status;
    logic                  w_is_data;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_wr_accept;
    logic                  w_wr_reject;
    logic [1:0]            w_lock_next;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_wr        = chip_select & write_en;
    assign w_rd        = chip_select & read_en;
    assign w_is_lock   = (addr == ADDR_LOCK);
    assign w_is_status = (addr == ADDR_STATUS);
    // Addresses below DATA_BASE wrap to large offsets and fall outside the range check.
    assign w_offset    = addr - DATA_BASE;
    assign w_is_data   = ({1'b0, w_offset} < NUM_REGS_A);
    assign w_idx       = w_offset[IDX_W-1:0];

    assign w_wr_accept = w_wr & w_is_data & (~LOCK_MASK[w_idx] | (r_lock_state == UNLOCKED));
    assign w_wr_reject = w_wr & ~w_is_lock & ~w_is_status & ~w_wr_accept;

`ifdef LOCKABLE_REGFILE_TIMEOUT_EN
    localparam int                 CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_timeout;
    assign w_timeout = (r_lock_state == UNLOCKED) && (r_idle_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if ((w_lock_next != UNLOCKED) || (w_wr && !w_wr_reject)) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_lock_next = r_lock_state;
        if (w_wr) begin
            case (r_lock_state)
                LOCKED:    if (w_is_lock && write_data == KEY1) w_lock_next = KEY1_SEEN;
                KEY1_SEEN: w_lock_next = (w_is_lock && write_data == KEY2) ? UNLOCKED : LOCKED;
                UNLOCKED:  if (w_is_lock) w_lock_next = LOCKED;
                default:   w_lock_next = LOCKED;
            endcase
        end
`ifdef LOCKABLE_REGFILE_TIMEOUT_EN
        if (w_timeout) w_lock_next = LOCKED;
`endif
    end

    always_comb begin
        w_status        = '0;
        w_status[15:8]  = r_err_cnt;
        w_status[1:0]   = r_lock_state;
    end

    always_comb begin
        w_rd_val = '0;
        if (w_is_status) w_rd_val = w_status;
        else if (w_is_data) w_rd_val = r_regs[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_state <= LOCKED;
            r_err_cnt    <= '0;
            r_read_data  <= '0;
            r_data_valid <= 1'b0;
            r_write_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            r_lock_state <= w_lock_next;
            r_data_valid <= w_rd;
            r_write_err  <= w_wr_reject;
            if (w_rd) r_read_data <= w_rd_val;
            // A STATUS clear wins over a same-cycle increment.
            if (w_wr && w_is_status) r_err_cnt <= '0;
            else if (w_wr_reject && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_wr_accept) r_regs[w_idx] <= write_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign read_data  = r_read_data;
    assign data_valid = r_data_valid;
    assign write_err  = r_write_err;
    assign lock_state = r_lock_state;
endmodule

// File: tb/tb_lockable_regfile.sv
// Directed bench for lockable_regfile: vector table of bus cycles plus reset, saturation and timeout sequences.
module tb_lockable_regfile;
`ifdef LOCKABLE_REGFILE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   addr;
    logic         chip_select, write_en, read_en;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic         data_valid, write_err;
    logic [1:0]   lock_state;
    logic [255:0] reg_out;

    int n_tests = 0;
    int n_fail  = 0;

    lockable_regfile #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .addr(addr), .chip_select(chip_select),
        .write_en(write_en), .read_en(read_en), .write_data(write_data),
        .read_data(read_data), .data_valid(data_valid), .write_err(write_err),
        .lock_state(lock_state), .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs, we, re;
        logic [7:0]  a;
        logic [31:0] d;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_valid, exp_err;
        logic [1:0]  exp_lock;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cs, logic we, logic re, logic [7:0] a, logic [31:0] d,
                                logic chk, logic [31:0] erd, logic ev, logic ee, logic [1:0] el);
        vec_t v;
        v.cs = cs; v.we = we; v.re = re; v.a = a; v.d = d;
        v.chk_rd = chk; v.exp_rd = erd; v.exp_valid = ev; v.exp_err = ee; v.exp_lock = el;
        return v;
    endfunction

    function automatic vec_t vw(logic [7:0] a, logic [31:0] d, logic ee, logic [1:0] el);
        return mk(1'b1, 1'b1, 1'b0, a, d, 1'b0, 32'h0, 1'b0, ee, el);
    endfunction

    function automatic vec_t vr(logic [7:0] a, logic [31:0] erd, logic [1:0] el);
        return mk(1'b1, 1'b0, 1'b1, a, 32'h0, 1'b1, erd, 1'b1, 1'b0, el);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic cs, input logic we, input logic re,
                       input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        chip_select = cs; write_en = we; read_en = re; addr = a; write_data = d;
        @(posedge clk);
        #1;
        chip_select = 1'b0; write_en = 1'b0; read_en = 1'b0;
    endtask

    initial begin
        int first;
        rst = 1'b1; chip_select = 1'b0; write_en = 1'b0; read_en = 1'b0;
        addr = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_err", {31'h0, write_err}, 32'h0);
        chk("rst_lock", {30'h0, lock_state}, 32'h0);
        chk("rst_reg_out_lo", reg_out[31:0], 32'h0);
        chk("rst_reg_out_hi", reg_out[255:224], 32'h0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back(vr(8'h10, 32'h0, 2'd0));
        vecs.push_back(vr(8'h17, 32'h0, 2'd0));
        vecs.push_back(vr(8'h01, 32'h0, 2'd0));
        vecs.push_back(vr(8'h00, 32'h0, 2'd0));
        vecs.push_back(vw(8'h10, 32'hDEADBEEF, 1'b1, 2'd0));
        vecs.push_back(vr(8'h10, 32'h0, 2'd0));
        vecs.push_back(vr(8'h01, 32'h100, 2'd0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 32'hA5A5, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0));
        vecs.push_back(vw(8'h00, 32'hA5A5, 1'b0, 2'd1));
        vecs.push_back(vw(8'h00, 32'h5A5A, 1'b0, 2'd2));
        vecs.push_back(vw(8'h10, 32'hDEADBEEF, 1'b0, 2'd2));
        vecs.push_back(vr(8'h10, 32'hDEADBEEF, 2'd2));
        vecs.push_back(vr(8'h00, 32'h0, 2'd2));
        vecs.push_back(vw(8'h00, 32'h0, 1'b0, 2'd0));
        vecs.push_back(vr(8'h01, 32'h100, 2'd0));
        vecs.push_back(vw(8'h01, 32'hFFFFFFFF, 1'b0, 2'd0));
        vecs.push_back(vr(8'h01, 32'h0, 2'd0));
        vecs.push_back(vw(8'h00, 32'hA5A5, 1'b0, 2'd1));
        vecs.push_back(vw(8'h11, 32'h1234, 1'b1, 2'd0));
        vecs.push_back(vw(8'h00, 32'h5A5A, 1'b0, 2'd0));
        vecs.push_back(vr(8'h11, 32'h0, 2'd0));
        vecs.push_back(vr(8'h01, 32'h100, 2'd0));
        vecs.push_back(vw(8'h20, 32'h77, 1'b1, 2'd0));
        vecs.push_back(vr(8'h20, 32'h0, 2'd0));
        vecs.push_back(vr(8'h01, 32'h200, 2'd0));
        vecs.push_back(vw(8'h00, 32'hA5A5, 1'b0, 2'd1));
        vecs.push_back(vw(8'h00, 32'h1111, 1'b0, 2'd0));
        vecs.push_back(vw(8'h00, 32'hA5A5, 1'b0, 2'd1));
        vecs.push_back(vw(8'h01, 32'h0, 1'b0, 2'd0));
        vecs.push_back(vr(8'h01, 32'h0, 2'd0));
        vecs.push_back(vw(8'h00, 32'hA5A5, 1'b0, 2'd1));
        vecs.push_back(vw(8'h00, 32'h5A5A, 1'b0, 2'd2));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'h10, 32'h11111111, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 2'd2));
        vecs.push_back(vr(8'h10, 32'h11111111, 2'd2));
        vecs.push_back(vr(8'h01, 32'h2, 2'd2));
        vecs.push_back(vw(8'h01, 32'h0, 1'b0, 2'd2));
        vecs.push_back(vw(8'h3F, 32'h5, 1'b1, 2'd2));
        vecs.push_back(vr(8'h01, 32'h102, 2'd2));
        vecs.push_back(vw(8'h00, 32'h0, 1'b0, 2'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'h102, 1'b0, 1'b0, 2'd0));

        foreach (vecs[i]) begin
            bus(vecs[i].cs, vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d);
            chk($sformatf("v%0d_valid", i), {31'h0, data_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("v%0d_err", i), {31'h0, write_err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_lock", i), {30'h0, lock_state}, {30'h0, vecs[i].exp_lock});
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), read_data, vecs[i].exp_rd);
        end

        // reg_out mapping: register 3 written while unlocked, register 0 holds the earlier rd+wr value
        bus(1'b1, 1'b1, 1'b0, 8'h00, 32'hA5A5);
        bus(1'b1, 1'b1, 1'b0, 8'h00, 32'h5A5A);
        bus(1'b1, 1'b1, 1'b0, 8'h13, 32'h33333333);
        chk("reg_out_r3", reg_out[3*32 +: 32], 32'h33333333);
        chk("reg_out_r0", reg_out[0 +: 32], 32'h11111111);
        chk("reg_out_r1", reg_out[1*32 +: 32], 32'h0);
        bus(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        chk("relock", {30'h0, lock_state}, 32'h0);

        // error counter saturation then clear
        for (int k = 0; k < 300; k++) bus(1'b1, 1'b1, 1'b0, 8'h12, k);
        bus(1'b1, 1'b0, 1'b1, 8'h01, 32'h0);
        chk("sat_status", read_data, 32'h0000FF00);
        chk("sat_reg2", reg_out[2*32 +: 32], 32'h0);
        bus(1'b1, 1'b1, 1'b0, 8'h01, 32'h0);
        chk("clr_err", {31'h0, write_err}, 32'h0);
        bus(1'b1, 1'b0, 1'b1, 8'h01, 32'h0);
        chk("clr_status", read_data, 32'h0);

        // reset mid-sequence drops the pending key and the read issued with it
        bus(1'b1, 1'b1, 1'b0, 8'h00, 32'hA5A5);
        chk("mid_key1", {30'h0, lock_state}, 32'h1);
        @(negedge clk);
        rst = 1'b1; chip_select = 1'b1; read_en = 1'b1; addr = 8'h13;
        @(posedge clk);
        #1;
        chk("rst_rd_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_mid_lock", {30'h0, lock_state}, 32'h0);
        chk("rst_mid_r3", reg_out[3*32 +: 32], 32'h0);
        chip_select = 1'b0; read_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus(1'b1, 1'b1, 1'b0, 8'h00, 32'h5A5A);
        chk("post_rst_key2", {30'h0, lock_state}, 32'h0);

`ifdef LOCKABLE_REGFILE_TIMEOUT_EN
        bus(1'b1, 1'b1, 1'b0, 8'h00, 32'hA5A5);
        bus(1'b1, 1'b1, 1'b0, 8'h00, 32'h5A5A);
        chk("to_unlocked", {30'h0, lock_state}, 32'h2);
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (first == 0 && lock_state == 2'd0) first = n;
        end
        chk("to_cycles", first, 16);
        bus(1'b1, 1'b1, 1'b0, 8'h10, 32'h55);
        chk("to_rejected", {31'h0, write_err}, 32'h1);
`else
        first = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
